median3x3_scan: RTL and testbench
=================================

# median3x3_scan

Scan-and-filter engine sitting directly downstream of the 3x3 window memory. It sweeps the window's top-left address across the source image and issues the memory read. It then takes the nine window pixels, computes their median in a 3-stage comparator pipeline, and writes the result back to the filtered image at the window centre. One pixel is processed at a time, and rd and wr are never active in the same cycle.

## Interface
- IMG_SIZE, 256, image side length in pixels; legal range 3..256 (addresses are 8 bit)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- start  in  1  begin a full-image scan; sampled only in IDLE
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  one-cycle pulse when the scan is complete
- rd  out  1  window read request to memory
- addr_row_r, addr_col_r  out  8 each  window top-left row/col
- wr  out  1  filtered-pixel write request
- addr_row_w, addr_col_w  out  8 each  write row/col
- cl_pixel  out  8  filtered pixel value
- sw_pixel_1..sw_pixel_9  in  8 each  window pixels, row-major (1 = top-left, 9 = bottom-right)

## Operation
- Scan counters r and c each run 0..IMG_SIZE-3. c is the inner loop. The counters wrap c to 0 and increment r after c = IMG_SIZE-3.
- States and per-pixel sequence:
  - IDLE: start=1 → RD.
  - RD: rd=1, addr_*_r = r,c.
  - W1: wait cycle (memory input register).
  - CAP: sw_pixel_* are valid. Stage A loads.
  - S1: stage B loads.
  - S2: stage C loads.
  - WR: wr=1, addr_*_w = r+1,c+1, cl_pixel = stage C result.
  - After WR: RD for the next pixel, or the end state after the last pixel.
- End state without FILT_BORDER_EN: DONE. With it: BRD, then DONE.
- DONE: done=1 for one cycle, then IDLE.
- Median pipeline, all unsigned 8-bit compares:
  - Stage A (end of CAP) sorts each row into (lo, mid, hi).
  - Stage B (end of S1) computes max of the 3 lo values, median of the 3 mid values, and min of the 3 hi values.
  - Stage C (end of S2) takes the median of those three.
  - The result equals the exact median of the 9 inputs. Ties are resolved by value only.
- All outputs are registered and driven from the current state. rd, wr and done are 0 in any state not listed above. Addresses and cl_pixel hold their last value between uses.
- start while busy or in DONE is ignored.
- Reset mid-scan returns the block to IDLE with counters at 0. A write already accepted by memory may still complete.
- Reset values: busy, done, rd, wr = 0; all address outputs = 0; cl_pixel = 0; pipeline registers = 0; state = IDLE.

## Timing
- Memory read latency: rd sampled at the end of RD, window registered at the end of W1, window consumed at the end of CAP.
- Memory write: wr sampled at the end of WR and committed one edge later. That cycle is the next RD, in which the memory sees a registered rd of 0, so there is no rd/wr collision.
- Throughput is 6 cycles per pixel, for (IMG_SIZE-2)² pixels.
- Let cycle 0 be the cycle in which start=1 is sampled in IDLE.
  - RD of the first pixel is cycle 1.
  - Pixel k occupies cycles 6k+1..6k+6.
  - DONE falls in cycle 6(IMG_SIZE-2)²+1, plus 4·IMG_SIZE-4 if FILT_BORDER_EN is defined.
- Back-to-back scans: start may be asserted in the first IDLE cycle after DONE.

## Configuration
- FILT_BORDER_EN defined:
  - After the last interior WR, the block enters BRD.
  - BRD writes cl_pixel=0 with wr=1, one position per cycle, for 4·IMG_SIZE-4 cycles.
  - Order: row 0 cols 0..N-1; row N-1 cols 0..N-1; col 0 rows 1..N-2; col N-1 rows 1..N-2.
  - rd stays 0 throughout BRD.
- FILT_BORDER_EN undefined: the BRD state is absent and border pixels of the filtered image are never written.

## Test plan
All scenarios use IMG_SIZE=8, with memory pre-loaded through hierarchy and the filtered image pre-filled with 0xAA.
- rst=0 for 2 cycles with start=1 → all outputs 0, block stays in IDLE. With rst=1 and start low → no rd/wr activity.
- Constant source image of 50, pulse start → f(1..6,1..6)=50; done in cycle 217 (245 with FILT_BORDER_EN); rd and wr never high in the same cycle.
- Rows 0..2, cols 0..2 = 9,1,8 / 2,7,3 / 6,4,5, rest 0 → f(1,1)=5; WR for this pixel in cycle 6 with cl_pixel=5. Impulse of 255 at (3,3) in a zero image → f(2..4,2..4)=0.
- start held high through the whole scan → exactly one scan and one done pulse. rst=0 at cycle 40, then start → full correct scan; done 217 cycles after the new start.
- FILT_BORDER_EN defined → f(0,0), f(0,7), f(7,3) and f(4,7) = 0, and f(3,3) is the median. Undefined → those four border pixels remain 0xAA.

Source files
------------

// File: rtl/median3x3_scan.sv
// median3x3_scan: raster scan over a 3x3 window memory feeding a 3-stage median pipeline.
// Optional macro FILT_BORDER_EN: after the interior scan, zero-fill the filtered image border.

module median3x3_scan #(
    parameter int IMG_SIZE = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       rd,
    output logic [7:0] addr_row_r,
    output logic [7:0] addr_col_r,
    output logic       wr,
    output logic [7:0] addr_row_w,
    output logic [7:0] addr_col_w,
    output logic [7:0] cl_pixel,
    input  logic [7:0] sw_pixel_1,
    input  logic [7:0] sw_pixel_2,
    input  logic [7:0] sw_pixel_3,
    input  logic [7:0] sw_pixel_4,
    input  logic [7:0] sw_pixel_5,
    input  logic [7:0] sw_pixel_6,
    input  logic [7:0] sw_pixel_7,
    input  logic [7:0] sw_pixel_8,
    input  logic [7:0] sw_pixel_9
);

    localparam int DATA_W = 8;
    localparam logic [7:0] LAST_RC = 8'(IMG_SIZE - 3);

    typedef enum logic [3:0] {
        S_IDLE, S_RD, S_W1, S_CAP, S_S1, S_S2, S_WR, S_DONE
`ifdef FILT_BORDER_EN
        , S_BRD
`endif
    } state_t;

    state_t state_q, state_d;
    logic [7:0] r_q, r_d, c_q, c_d;
    logic busy_q, busy_d, done_q, done_d, rd_q, rd_d, wr_q, wr_d;
    logic [7:0] addr_row_r_q, addr_row_r_d, addr_col_r_q, addr_col_r_d;
    logic [7:0] addr_row_w_q, addr_row_w_d, addr_col_w_q, addr_col_w_d;
    logic [DATA_W-1:0] cl_pixel_q, cl_pixel_d;
    logic vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d;
    logic [2:0][DATA_W-1:0] lo_p0_q, lo_p0_d, mid_p0_q, mid_p0_d, hi_p0_q, hi_p0_d;
    logic [DATA_W-1:0] max_lo_p1_q, max_lo_p1_d, med_mid_p1_q, med_mid_p1_d;
    logic [DATA_W-1:0] min_hi_p1_q, min_hi_p1_d;

    function automatic logic [DATA_W-1:0] min2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a < b) ? b : a;
    endfunction

    function automatic logic [DATA_W-1:0] med3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                               input logic [DATA_W-1:0] c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    // Returns {hi, mid, lo}.
    function automatic logic [3*DATA_W-1:0] sort3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                                  input logic [DATA_W-1:0] c);
        return {max2(max2(a, b), c), med3(a, b, c), min2(min2(a, b), c)};
    endfunction

`ifdef FILT_BORDER_EN
    localparam logic [9:0] BRD_LAST = 10'(4 * IMG_SIZE - 5);
    localparam logic [9:0] SEG1     = 10'(IMG_SIZE);
    localparam logic [9:0] SEG2     = 10'(2 * IMG_SIZE);
    localparam logic [9:0] SEG3     = 10'(3 * IMG_SIZE - 2);
    localparam logic [7:0] EDGE     = 8'(IMG_SIZE - 1);

    logic [9:0] brd_q, brd_d;

    // Border walk: top row, bottom row, then left and right columns without corners.
    function automatic logic [15:0] brd_pos(input logic [9:0] idx);
        logic [7:0] row, col;
        if (idx < SEG1) begin
            row = 8'd0;
            col = 8'(idx);
        end else if (idx < SEG2) begin
            row = EDGE;
            col = 8'(idx - SEG1);
        end else if (idx < SEG3) begin
            row = 8'(idx - SEG2 + 10'd1);
            col = 8'd0;
        end else begin
            row = 8'(idx - SEG3 + 10'd1);
            col = EDGE;
        end
        return {row, col};
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
`ifdef FILT_BORDER_EN
        brd_d   = brd_q;
`endif
        unique case (state_q)
            S_IDLE: if (start) begin
                state_d = S_RD;
                r_d     = 8'd0;
                c_d     = 8'd0;
            end
            S_RD:  state_d = S_W1;
            S_W1:  state_d = S_CAP;
            S_CAP: state_d = S_S1;
            S_S1:  state_d = S_S2;
            S_S2:  state_d = S_WR;
            S_WR: begin
                if (r_q == LAST_RC && c_q == LAST_RC) begin
                    r_d = 8'd0;
                    c_d = 8'd0;
`ifdef FILT_BORDER_EN
                    state_d = S_BRD;
                    brd_d   = 10'd0;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_RD;
                    if (c_q == LAST_RC) begin
                        c_d = 8'd0;
                        r_d = r_q + 8'd1;
                    end else begin
                        c_d = c_q + 8'd1;
                    end
                end
            end
`ifdef FILT_BORDER_EN
            S_BRD: begin
                if (brd_q == BRD_LAST) state_d = S_DONE;
                else                   brd_d   = brd_q + 10'd1;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the state being entered.
        busy_d       = !(state_d inside {S_IDLE, S_DONE});
        done_d       = (state_d == S_DONE);
        rd_d         = (state_d == S_RD);
        wr_d         = (state_d == S_WR);
        addr_row_r_d = rd_d ? r_d : addr_row_r_q;
        addr_col_r_d = rd_d ? c_d : addr_col_r_q;
        addr_row_w_d = wr_d ? r_q + 8'd1 : addr_row_w_q;
        addr_col_w_d = wr_d ? c_q + 8'd1 : addr_col_w_q;

        // Stage A: sort each window row.
        vld_p0_d = (state_q == S_CAP);
        lo_p0_d  = lo_p0_q;
        mid_p0_d = mid_p0_q;
        hi_p0_d  = hi_p0_q;
        if (vld_p0_d) begin
            {hi_p0_d[0], mid_p0_d[0], lo_p0_d[0]} = sort3(sw_pixel_1, sw_pixel_2, sw_pixel_3);
            {hi_p0_d[1], mid_p0_d[1], lo_p0_d[1]} = sort3(sw_pixel_4, sw_pixel_5, sw_pixel_6);
            {hi_p0_d[2], mid_p0_d[2], lo_p0_d[2]} = sort3(sw_pixel_7, sw_pixel_8, sw_pixel_9);
        end

        // Stage B: max of lows, median of mids, min of highs.
        vld_p1_d     = vld_p0_q;
        max_lo_p1_d  = max_lo_p1_q;
        med_mid_p1_d = med_mid_p1_q;
        min_hi_p1_d  = min_hi_p1_q;
        if (vld_p0_q) begin
            max_lo_p1_d  = max2(max2(lo_p0_q[0], lo_p0_q[1]), lo_p0_q[2]);
            med_mid_p1_d = med3(mid_p0_q[0], mid_p0_q[1], mid_p0_q[2]);
            min_hi_p1_d  = min2(min2(hi_p0_q[0], hi_p0_q[1]), hi_p0_q[2]);
        end

        // Stage C: final median lands directly in the output register.
        cl_pixel_d = vld_p1_q ? med3(max_lo_p1_q, med_mid_p1_q, min_hi_p1_q) : cl_pixel_q;

`ifdef FILT_BORDER_EN
        if (state_d == S_BRD) begin
            wr_d                         = 1'b1;
            {addr_row_w_d, addr_col_w_d} = brd_pos(brd_d);
            cl_pixel_d                   = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            r_q          <= '0;
            c_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            addr_row_r_q <= '0;
            addr_col_r_q <= '0;
            addr_row_w_q <= '0;
            addr_col_w_q <= '0;
            cl_pixel_q   <= '0;
            vld_p0_q     <= 1'b0;
            vld_p1_q     <= 1'b0;
            lo_p0_q      <= '0;
            mid_p0_q     <= '0;
            hi_p0_q      <= '0;
            max_lo_p1_q  <= '0;
            med_mid_p1_q <= '0;
            min_hi_p1_q  <= '0;
`ifdef FILT_BORDER_EN
            brd_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            r_q          <= r_d;
            c_q          <= c_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            addr_row_r_q <= addr_row_r_d;
            addr_col_r_q <= addr_col_r_d;
            addr_row_w_q <= addr_row_w_d;
            addr_col_w_q <= addr_col_w_d;
            cl_pixel_q   <= cl_pixel_d;
            vld_p0_q     <= vld_p0_d;
            vld_p1_q     <= vld_p1_d;
            lo_p0_q      <= lo_p0_d;
            mid_p0_q     <= mid_p0_d;
            hi_p0_q      <= hi_p0_d;
            max_lo_p1_q  <= max_lo_p1_d;
            med_mid_p1_q <= med_mid_p1_d;
            min_hi_p1_q  <= min_hi_p1_d;
`ifdef FILT_BORDER_EN
            brd_q        <= brd_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign rd         = rd_q;
    assign wr         = wr_q;
    assign addr_row_r = addr_row_r_q;
    assign addr_col_r = addr_col_r_q;
    assign addr_row_w = addr_row_w_q;
    assign addr_col_w = addr_col_w_q;
    assign cl_pixel   = cl_pixel_q;

endmodule

// File: tb/tb_median3x3_scan.sv
// Directed testbench for median3x3_scan at IMG_SIZE=8 with a behavioural window/filtered-image memory.
// Honours FILT_BORDER_EN for done timing and border expectations.

module tb_median3x3_scan;

    localparam int N = 8;
`ifdef FILT_BORDER_EN
    localparam int         EXP_DONE = 245;
    localparam logic [7:0] EXP_BRD  = 8'h00;
`else
    localparam int         EXP_DONE = 217;
    localparam logic [7:0] EXP_BRD  = 8'hAA;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic busy, done, rd, wr;
    logic [7:0] addr_row_r, addr_col_r, addr_row_w, addr_col_w, cl_pixel;
    logic [7:0] sw_pix [1:9];

    logic [7:0] src  [N][N];
    logic [7:0] filt [N][N];
    logic       clr_filt = 1'b0;

    logic       rd_s = 1'b0, wr_s = 1'b0;
    logic [2:0] ar = '0, ac = '0, wrr = '0, wrc = '0;
    logic [7:0] wd = '0;

    int errors = 0, checks = 0, cyc = 0;
    int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, coll_cnt = 0;

    median3x3_scan #(.IMG_SIZE(N)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd(rd), .addr_row_r(addr_row_r), .addr_col_r(addr_col_r),
        .wr(wr), .addr_row_w(addr_row_w), .addr_col_w(addr_col_w), .cl_pixel(cl_pixel),
        .sw_pixel_1(sw_pix[1]), .sw_pixel_2(sw_pix[2]), .sw_pixel_3(sw_pix[3]),
        .sw_pixel_4(sw_pix[4]), .sw_pixel_5(sw_pix[5]), .sw_pixel_6(sw_pix[6]),
        .sw_pixel_7(sw_pix[7]), .sw_pixel_8(sw_pix[8]), .sw_pixel_9(sw_pix[9])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Window memory: rd registered, window registered one edge later; writes commit two edges after wr.
    always @(posedge clk) begin
        rd_s <= rd;
        ar   <= addr_row_r[2:0];
        ac   <= addr_col_r[2:0];
        if (rd_s) begin
            sw_pix[1] <= src[ar][ac];
            sw_pix[2] <= src[ar][ac + 3'd1];
            sw_pix[3] <= src[ar][ac + 3'd2];
            sw_pix[4] <= src[ar + 3'd1][ac];
            sw_pix[5] <= src[ar + 3'd1][ac + 3'd1];
            sw_pix[6] <= src[ar + 3'd1][ac + 3'd2];
            sw_pix[7] <= src[ar + 3'd2][ac];
            sw_pix[8] <= src[ar + 3'd2][ac + 3'd1];
            sw_pix[9] <= src[ar + 3'd2][ac + 3'd2];
        end
        wr_s <= wr;
        wrr  <= addr_row_w[2:0];
        wrc  <= addr_col_w[2:0];
        wd   <= cl_pixel;
        if (clr_filt) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    filt[3'(i)][3'(j)] <= 8'hAA;
        end else if (wr_s) begin
            filt[wrr][wrc] <= wd;
        end
    end

    always @(negedge clk) begin
        if (rd === 1'b1) rd_cnt++;
        if (wr === 1'b1) wr_cnt++;
        if (done === 1'b1) done_cnt++;
        if (rd === 1'b1 && wr === 1'b1) coll_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fill_src(input logic [7:0] v);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                src[3'(i)][3'(j)] = v;
    endtask

    task automatic prefill_filt();
        @(negedge clk) clr_filt = 1'b1;
        @(negedge clk) clr_filt = 1'b0;
    endtask

    task automatic run_scan(input bit hold, output int done_at, output int wr_at,
                            output logic [7:0] wr_px, output logic [15:0] wr_addr);
        int t0;
        done_at = -1;
        wr_at   = -1;
        wr_px   = '0;
        wr_addr = '0;
        @(negedge clk);
        start = 1'b1;
        t0    = cyc;
        @(negedge clk);
        if (!hold) start = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (wr === 1'b1 && wr_at < 0) begin
                wr_at   = cyc - t0;
                wr_px   = cl_pixel;
                wr_addr = {addr_row_w, addr_col_w};
            end
            if (done === 1'b1) begin
                done_at = cyc - t0;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int done_at, wr_at, rd0, wr0, dn0, t0;
        logic [7:0]  wr_px;
        logic [15:0] wr_addr;

        // Reset held with start asserted.
        rst   = 1'b0;
        start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl", {28'd0, busy, done, rd, wr}, 32'd0);
        chk("rst_addr_r", {16'd0, addr_row_r, addr_col_r}, 32'd0);
        chk("rst_addr_w", {16'd0, addr_row_w, addr_col_w}, 32'd0);
        chk("rst_pixel", {24'd0, cl_pixel}, 32'd0);
        rst   = 1'b1;
        start = 1'b0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        repeat (10) @(negedge clk);
        chk("idle_no_rdwr", rd_cnt - rd0 + wr_cnt - wr0, 0);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Constant image.
        fill_src(8'd50);
        prefill_filt();
        rd0 = rd_cnt;
        run_scan(1'b0, done_at, wr_at, wr_px, wr_addr);
        chk("const_done_cycle", done_at, EXP_DONE);
        chk("const_rd_count", rd_cnt - rd0, 36);
        for (int r = 1; r < N - 1; r++)
            for (int c = 1; c < N - 1; c++)
                chk($sformatf("const_f_%0d_%0d", r, c), {24'd0, filt[3'(r)][3'(c)]}, 32'd50);
        chk("border_0_0", {24'd0, filt[0][0]}, {24'd0, EXP_BRD});
        chk("border_0_7", {24'd0, filt[0][7]}, {24'd0, EXP_BRD});
        chk("border_7_3", {24'd0, filt[7][3]}, {24'd0, EXP_BRD});
        chk("border_4_7", {24'd0, filt[4][7]}, {24'd0, EXP_BRD});
        chk("const_f_3_3", {24'd0, filt[3][3]}, 32'd50);

        // Scrambled 1..9 corner window; median 5.
        fill_src(8'd0);
        src[0][0] = 8'd9; src[0][1] = 8'd1; src[0][2] = 8'd8;
        src[1][0] = 8'd2; src[1][1] = 8'd7; src[1][2] = 8'd3;
        src[2][0] = 8'd6; src[2][1] = 8'd4; src[2][2] = 8'd5;
        prefill_filt();
        run_scan(1'b0, done_at, wr_at, wr_px, wr_addr);
        chk("med_first_wr_cycle", wr_at, 6);
        chk("med_first_wr_pixel", {24'd0, wr_px}, 32'd5);
        chk("med_first_wr_addr", {16'd0, wr_addr}, 32'h0101);
        chk("med_f_1_1", {24'd0, filt[1][1]}, 32'd5);

        // Single bright impulse is removed.
        fill_src(8'd0);
        src[3][3] = 8'd255;
        prefill_filt();
        run_scan(1'b0, done_at, wr_at, wr_px, wr_addr);
        for (int r = 2; r <= 4; r++)
            for (int c = 2; c <= 4; c++)
                chk($sformatf("imp_f_%0d_%0d", r, c), {24'd0, filt[3'(r)][3'(c)]}, 32'd0);

        // start held high across the scan.
        fill_src(8'd50);
        rd0 = rd_cnt;
        dn0 = done_cnt;
        run_scan(1'b1, done_at, wr_at, wr_px, wr_addr);
        repeat (20) @(negedge clk);
        chk("hold_done_cycle", done_at, EXP_DONE);
        chk("hold_done_pulses", done_cnt - dn0, 1);
        chk("hold_rd_count", rd_cnt - rd0, 36);
        chk("hold_idle", {31'd0, busy}, 32'd0);

        // Reset in the middle of a scan, then a full gradient scan.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                src[3'(i)][3'(j)] = 8'(i * 8 + j);
        @(negedge clk);
        start = 1'b1;
        t0    = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        chk("midrst_was_busy", {31'd0, busy}, 32'd1);
        chk("midrst_at_cycle", cyc - t0, 40);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midrst_ctl", {28'd0, busy, done, rd, wr}, 32'd0);
        chk("midrst_addr_r", {16'd0, addr_row_r, addr_col_r}, 32'd0);
        repeat (3) @(negedge clk);
        prefill_filt();
        run_scan(1'b0, done_at, wr_at, wr_px, wr_addr);
        chk("grad_done_cycle", done_at, EXP_DONE);
        for (int r = 1; r < N - 1; r++)
            for (int c = 1; c < N - 1; c++)
                chk($sformatf("grad_f_%0d_%0d", r, c), {24'd0, filt[3'(r)][3'(c)]}, 32'(r * 8 + c));
        chk("grad_border_0_0", {24'd0, filt[0][0]}, {24'd0, EXP_BRD});
        chk("grad_border_4_7", {24'd0, filt[4][7]}, {24'd0, EXP_BRD});

        chk("rd_wr_collisions", coll_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
